// File: rtl/mem_port_arbiter4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter4
//   Round-robin arbiter and sequencer sharing one 32-bit memory/datapath port
//   among four requesters. A transfer runs IDLE -> GRANT -> RELEASE. The GRANT
//   phase is bounded by an optional watchdog so that a hung port cannot lock out
//   the other requesters. All outputs are registered.
//
// Parameters
//   TIMEOUT  GRANT cycles allowed without MemAck before abort (0 = no watchdog)
//
// Ports
//   CLK     in   system clock, rising edge
//   Reset   in   asynchronous active-low reset
//   Req     in   [3:0] request vector, bit i = requester i
//   MemAck  in   shared port completion strobe, only looked at in GRANT
//   MemReq  out  request to the shared port, high throughout GRANT
//   Grant   out  [3:0] one-hot owner, zero outside GRANT
//   Sel     out  [1:0] index of current/last owner, drives the 4:1 data mux
//   Busy    out  high in GRANT and RELEASE
//   Done    out  [3:0] one-cycle completion pulse to the owner
//   Err     out  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mem_port_arbiter4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       MemAck,
  output logic       MemReq,
  output logic [3:0] Grant,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic [3:0] Done,
  output logic       Err
);

  localparam int unsigned    CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e        state_q,   state_d;
  logic [1:0]    ptr_q,     ptr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [3:0]    grant_q,   grant_d;
  logic [1:0]    sel_q,     sel_d;
  logic          busy_q,    busy_d;
  logic [3:0]    done_q,    done_d;
  logic          err_q,     err_d;

  // Round-robin pick: first set request scanning ptr, ptr+1, ... (mod 4).
  logic [1:0] pick_idx;
  logic       pick_vld;

  always_comb begin
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!pick_vld && Req[ptr_q + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 2'(k);
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = '0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d   = S_GRANT;
          grant_d   = 4'b0001 << pick_idx;
          sel_d     = pick_idx;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end

      S_GRANT: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (MemAck || (WDOG_EN && cnt_q == CNT_LAST)) begin
          done_d    = MemAck ? grant_q : 4'b0000;
          err_d     = !MemAck;
          mem_req_d = 1'b0;
          grant_d   = '0;
          ptr_d     = sel_q + 2'd1;
          state_d   = S_RELEASE;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RELEASE: begin
        // Single bubble cycle; Sel is held so the mux stays stable.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        grant_d   = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign MemReq = mem_req_q;
  assign Grant  = grant_q;
  assign Sel    = sel_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter4
//   Directed scenarios followed by random Req/MemAck traffic. Expected outputs
//   come from a transaction-level model: who owns the port, how long it has
//   owned it, whether a bubble is pending, and the round-robin pointer.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter4;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Req;
  logic       MemAck;
  logic       MemReq;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Busy;
  logic [3:0] Done;
  logic       Err;

  always #5 CLK = ~CLK;

  mem_port_arbiter4 #(.TIMEOUT(TO)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .Req    (Req),
    .MemAck (MemAck),
    .MemReq (MemReq),
    .Grant  (Grant),
    .Sel    (Sel),
    .Busy   (Busy),
    .Done   (Done),
    .Err    (Err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_owner;   // -1 when nobody owns the port
  int         m_age;     // GRANT cycles elapsed without ack
  int         m_ptr;     // next index to scan from
  bit         m_bubble;  // release cycle pending
  logic [1:0] m_sel;
  logic [3:0] m_done;
  logic       m_err;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_age    = 0;
    m_ptr    = 0;
    m_bubble = 1'b0;
    m_sel    = 2'd0;
    m_done   = 4'b0;
    m_err    = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_step(input logic [3:0] req, input logic ack);
    m_done = 4'b0;
    m_err  = 1'b0;
    if (m_owner >= 0) begin
      if (ack) begin
        m_done   = 4'(1 << m_owner);
        m_ptr    = (m_owner + 1) % 4;
        m_owner  = -1;
        m_bubble = 1'b1;
      end else if (TO != 0 && m_age == TO - 1) begin
        m_err    = 1'b1;
        m_ptr    = (m_owner + 1) % 4;
        m_owner  = -1;
        m_bubble = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (req != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_sel   = 2'(j);
          m_age   = 0;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] e_grant;
    logic       e_req;
    logic       e_busy;
    e_req   = (m_owner >= 0);
    e_grant = e_req ? 4'(1 << m_owner) : 4'b0;
    e_busy  = e_req || m_bubble;
    check({tag, " MemReq"}, {3'b0, MemReq}, {3'b0, e_req});
    check({tag, " Grant"},  Grant,          e_grant);
    check({tag, " Sel"},    {2'b0, Sel},    {2'b0, m_sel});
    check({tag, " Busy"},   {3'b0, Busy},   {3'b0, e_busy});
    check({tag, " Done"},   Done,           m_done);
    check({tag, " Err"},    {3'b0, Err},    {3'b0, m_err});
  endtask

  // One clock: update the model, take the edge, sample 1 ns later and compare.
  task automatic step(input string tag);
    model_step(Req, MemAck);
    @(posedge CLK);
    #1;
    compare_model(tag);
  endtask

  initial begin
    int last_grant_cyc;
    int n_grants;
    logic prev_req;

    // ---- Reset held with all requests high ----
    Reset  = 1'b0;
    Req    = 4'b1111;
    MemAck = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst MemReq", {3'b0, MemReq}, 4'h0);
    check("rst Grant",  Grant,          4'h0);
    check("rst Sel",    {2'b0, Sel},    4'h0);
    check("rst Busy",   {3'b0, Busy},   4'h0);
    check("rst Done",   Done,           4'h0);
    check("rst Err",    {3'b0, Err},    4'h0);

    Reset = 1'b1;
    step("rst_rel");
    check("rst_rel Grant",  Grant,          4'b0001);
    check("rst_rel MemReq", {3'b0, MemReq}, 4'h1);
    MemAck = 1'b1;
    step("rst_ack");
    MemAck = 1'b0;
    Req    = 4'b0;
    step("rst_bubble");
    step("rst_idle");

    // ---- Single requester, ack on the 3rd GRANT cycle ----
    Req = 4'b0100;
    step("single g1");
    step("single g2");
    step("single g3");
    MemAck = 1'b1;
    step("single ack");
    check("single Done", Done,         4'b0100);
    check("single Busy", {3'b0, Busy}, 4'h1);
    MemAck = 1'b0;
    Req    = 4'b0;
    step("single rel");
    check("single Busy0", {3'b0, Busy}, 4'h0);
    // Pointer now 3: index 3 must beat index 0.
    Req = 4'b1001;
    step("single ptr");
    check("single ptr Grant", Grant, 4'b1000);
    MemAck = 1'b1;
    Req    = 4'b0;
    step("single ptr ack");
    step("single ptr rel");

    // ---- Round-robin fairness: all requesting, ack tied high ----
    Req            = 4'b1111;
    last_grant_cyc = 0;
    n_grants       = 0;
    prev_req       = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      step("rr");
      if (MemReq && !prev_req) begin
        check("rr order", {2'b0, Sel}, 4'(n_grants % 4));
        if (n_grants > 0) check("rr spacing", 4'(c - last_grant_cyc), 4'd3);
        last_grant_cyc = c;
        n_grants++;
      end
      prev_req = MemReq;
    end
    check("rr count", 4'(n_grants), 4'd5);
    Req    = 4'b0;
    MemAck = 1'b0;
    step("rr idle");

    // ---- Watchdog abort ----
    Req = 4'b0010;
    step("wd grant");
    check("wd Grant", Grant, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      step("wd wait");
      check("wd no Err", {3'b0, Err}, 4'h0);
    end
    step("wd abort");
    check("wd Err",  {3'b0, Err}, 4'h1);
    check("wd Done", Done,        4'h0);
    Req = 4'b0;
    step("wd rel");
    Req = 4'b1111;
    step("wd next");
    check("wd next Grant", Grant, 4'b0100);
    MemAck = 1'b1;
    Req    = 4'b0;
    step("wd next ack");
    MemAck = 1'b0;
    step("wd next rel");

    // ---- Ack on the same cycle as the timeout ----
    Req = 4'b0010;
    step("tie g1");
    step("tie g2");
    step("tie g3");
    step("tie g4");
    MemAck = 1'b1;
    step("tie ack");
    check("tie Done", Done,        4'b0010);
    check("tie Err",  {3'b0, Err}, 4'h0);
    MemAck = 1'b0;
    Req    = 4'b0;
    step("tie rel");

    // ---- Asynchronous reset mid-transfer ----
    Req = 4'b0001;
    step("mid grant");
    #2;
    Reset = 1'b0;
    #1;
    check("mid MemReq", {3'b0, MemReq}, 4'h0);
    check("mid Grant",  Grant,          4'h0);
    check("mid Busy",   {3'b0, Busy},   4'h0);
    model_reset();
    @(posedge CLK);
    #1;
    check("mid Done", Done,        4'h0);
    check("mid Err",  {3'b0, Err}, 4'h0);
    Reset = 1'b1;
    Req   = 4'b1111;
    step("mid restart");
    check("mid restart Grant", Grant, 4'b0001);

    // ---- Random traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      Req    = 4'($urandom_range(0, 15));
      MemAck = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
